// File: rtl/elpis_print_buffer_pkg.sv
// Shared widths and helpers for the Elpis print capture buffer.
package elpis_print_buffer_pkg;

   localparam int unsigned PRINT_W          = 32;
   localparam int unsigned PRINT_FIFO_DEPTH = 8;
   localparam int unsigned DROP_CNT_W       = 16;

   typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

   function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/elpis_sync_fifo.sv
// Synchronous FIFO holding captured print words; read data is the head entry, unregistered.
module elpis_sync_fifo
   import elpis_print_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = PRINT_FIFO_DEPTH,
   parameter int unsigned ADDR_W = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_wr,
   input  logic [PRINT_W-1:0] i_wr_data,
   input  logic               i_rd,
   output logic [PRINT_W-1:0] o_rd_data,
   output logic [ADDR_W:0]    o_count,
   output logic               o_full,
   output logic               o_empty
);

   localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

   logic [PRINT_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0]  r_wr_ptr;
   logic [ADDR_W-1:0]  r_rd_ptr;
   logic [ADDR_W:0]    r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (i_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_wr, i_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);

endmodule

// File: rtl/elpis_print_buffer.sv
// Captures Elpis print words into a FIFO for the host to drain via a request/valid handshake;
// captures arriving while full are dropped and counted.
module elpis_print_buffer
   import elpis_print_buffer_pkg::*;
#(
   parameter int unsigned DEPTH           = PRINT_FIFO_DEPTH,
   parameter int unsigned ADDR_W          = 3,
   parameter int unsigned CAPTURE_ON_EDGE = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_print_valid,
   input  logic [PRINT_W-1:0]    i_print_data,
   input  logic                  i_host_rd_req,
   output logic [PRINT_W-1:0]    o_host_rd_data,
   output logic                  o_host_rd_valid,
   output logic [ADDR_W:0]       o_fifo_count,
   output logic                  o_fifo_empty,
   output logic                  o_fifo_full,
   output logic                  o_overflow,
   output logic [DROP_CNT_W-1:0] o_drop_count,
   input  logic                  i_clear_overflow
);

   logic                  r_prev_valid;
   logic [PRINT_W-1:0]    r_host_rd_data;
   logic                  r_host_rd_valid;
   logic                  r_overflow;
   drop_cnt_t             r_drop_count;

   logic                  w_capture;
   logic                  w_rd;
   logic                  w_wr;
   logic                  w_drop;
   logic [PRINT_W-1:0]    w_fifo_rd_data;

   assign w_capture = (CAPTURE_ON_EDGE != 0) ? (i_print_valid & ~r_prev_valid) : i_print_valid;
   // Requests against an empty FIFO are discarded, never queued or bypassed.
   assign w_rd      = i_host_rd_req & ~o_fifo_empty;
   assign w_wr      = w_capture & (~o_fifo_full | w_rd);
   assign w_drop    = w_capture & o_fifo_full & ~w_rd;

   elpis_sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr      (w_wr),
      .i_wr_data (i_print_data),
      .i_rd      (w_rd),
      .o_rd_data (w_fifo_rd_data),
      .o_count   (o_fifo_count),
      .o_full    (o_fifo_full),
      .o_empty   (o_fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_prev_valid    <= 1'b0;
         r_host_rd_data  <= '0;
         r_host_rd_valid <= 1'b0;
         r_overflow      <= 1'b0;
         r_drop_count    <= '0;
      end else begin
         r_prev_valid    <= i_print_valid;
         r_host_rd_valid <= w_rd;
         if (w_rd) r_host_rd_data <= w_fifo_rd_data;
         // A drop coinciding with a clear wins and restarts the count at one.
         if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= i_clear_overflow ? drop_cnt_t'(1) : sat_inc(r_drop_count);
         end else if (i_clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
         end
      end
   end

   assign o_host_rd_data  = r_host_rd_data;
   assign o_host_rd_valid = r_host_rd_valid;
   assign o_overflow      = r_overflow;
   assign o_drop_count    = r_drop_count;

endmodule

// File: tb/tb_elpis_print_buffer.sv
// Directed bench for elpis_print_buffer: vector table plus hand-written multi-cycle sequences.
module tb_elpis_print_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        print_valid;
   logic [31:0] print_data;
   logic        host_rd_req;
   logic [31:0] host_rd_data;
   logic        host_rd_valid;
   logic [3:0]  fifo_count;
   logic        fifo_empty;
   logic        fifo_full;
   logic        overflow;
   logic [15:0] drop_count;
   logic        clear_overflow;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   elpis_print_buffer #(
      .DEPTH           (8),
      .ADDR_W          (3),
      .CAPTURE_ON_EDGE (1)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_print_valid    (print_valid),
      .i_print_data     (print_data),
      .i_host_rd_req    (host_rd_req),
      .o_host_rd_data   (host_rd_data),
      .o_host_rd_valid  (host_rd_valid),
      .o_fifo_count     (fifo_count),
      .o_fifo_empty     (fifo_empty),
      .o_fifo_full      (fifo_full),
      .o_overflow       (overflow),
      .o_drop_count     (drop_count),
      .i_clear_overflow (clear_overflow)
   );

   typedef struct {
      logic        pv;
      logic [31:0] pd;
      logic        rq;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ec;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic pv, input logic [31:0] pd, input logic rq,
                               input logic ev, input logic [31:0] ed, input logic [3:0] ec);
      vec_t v;
      v.pv = pv; v.pd = pd; v.rq = rq; v.ev = ev; v.ed = ed; v.ec = ec;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic pv, input logic [31:0] pd, input logic rq, input logic clr);
      print_valid    = pv;
      print_data     = pd;
      host_rd_req    = rq;
      clear_overflow = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string nm, input logic ev, input logic [31:0] ed,
                            input logic [3:0] ec, input logic eo, input logic [15:0] edc);
      chk({nm, ".valid"}, {31'b0, host_rd_valid}, {31'b0, ev});
      if (ev) chk({nm, ".data"}, host_rd_data, ed);
      chk({nm, ".count"}, {28'b0, fifo_count}, {28'b0, ec});
      chk({nm, ".empty"}, {31'b0, fifo_empty}, {31'b0, (ec == 4'd0)});
      chk({nm, ".full"}, {31'b0, fifo_full}, {31'b0, (ec == 4'd8)});
      chk({nm, ".ovf"}, {31'b0, overflow}, {31'b0, eo});
      chk({nm, ".drops"}, {16'b0, drop_count}, {16'b0, edc});
   endtask

   // One rising-edge capture: valid high for a cycle, then low.
   task automatic capture_word(input logic [31:0] d, input logic [3:0] ec, input logic eo,
                               input logic [15:0] edc);
      drv(1'b1, d, 1'b0, 1'b0);
      step();
      chk_state("cap", 1'b0, 32'h0, ec, eo, edc);
      drv(1'b0, 32'h0, 1'b0, 1'b0);
      step();
   endtask

   initial begin
      // Test 1, 2 and 5 as a vector table; state is checked just after each edge.
      vecs[0]  = mk(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        4'd1);
      vecs[1]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 4'd0);
      vecs[2]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd0);
      vecs[3]  = mk(1'b1, 32'h1,        1'b0, 1'b0, 32'h0,        4'd1);
      vecs[4]  = mk(1'b1, 32'h1,        1'b0, 1'b0, 32'h0,        4'd1);
      vecs[5]  = mk(1'b1, 32'h1,        1'b0, 1'b0, 32'h0,        4'd1);
      vecs[6]  = mk(1'b1, 32'h1,        1'b0, 1'b0, 32'h0,        4'd1);
      vecs[7]  = mk(1'b1, 32'h1,        1'b0, 1'b0, 32'h0,        4'd1);
      vecs[8]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd1);
      vecs[9]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h1,        4'd0);
      vecs[10] = mk(1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd0);
      vecs[11] = mk(1'b1, 32'h55,       1'b1, 1'b0, 32'h0,        4'd1);
      vecs[12] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h55,       4'd0);
      vecs[13] = mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        4'd0);
      vecs[14] = mk(1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd0);

      reset = 1'b1;
      drv(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      chk_state("reset", 1'b0, 32'h0, 4'd0, 1'b0, 16'd0);
      chk("reset.data", host_rd_data, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drv(vecs[i].pv, vecs[i].pd, vecs[i].rq, 1'b0);
         step();
         chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, 1'b0, 16'd0);
      end

      // Test 3: ten captures into eight entries, then drain back-to-back.
      for (int i = 0; i < 10; i++) begin
         capture_word(i, (i < 8) ? 4'(i + 1) : 4'd8, (i >= 8), (i >= 8) ? 16'(i - 7) : 16'd0);
      end
      chk_state("full10", 1'b0, 32'h0, 4'd8, 1'b1, 16'd2);
      for (int i = 0; i < 8; i++) begin
         drv(1'b0, 32'h0, 1'b1, 1'b0);
         step();
         chk_state($sformatf("drain%0d", i), 1'b1, i, 4'(7 - i), 1'b1, 16'd2);
      end
      step();
      chk_state("drain_end", 1'b0, 32'h0, 4'd0, 1'b1, 16'd2);
      drv(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      chk_state("clear", 1'b0, 32'h0, 4'd0, 1'b0, 16'd0);

      // Test 4: simultaneous capture and read while full.
      for (int i = 0; i < 8; i++) capture_word(200 + i, 4'(i + 1), 1'b0, 16'd0);
      drv(1'b1, 32'hA5, 1'b1, 1'b0);
      step();
      chk_state("full_rw", 1'b1, 32'd200, 4'd8, 1'b0, 16'd0);
      for (int i = 0; i < 8; i++) begin
         drv(1'b0, 32'h0, 1'b1, 1'b0);
         step();
         chk_state($sformatf("drain_rw%0d", i), 1'b1, (i < 7) ? 32'(201 + i) : 32'hA5,
                   4'(7 - i), 1'b0, 16'd0);
      end
      drv(1'b0, 32'h0, 1'b0, 1'b0);
      step();

      // Test 6: pointer wrap over write/read pairs.
      for (int i = 0; i < 20; i++) begin
         drv(1'b1, 32'(100 + i), 1'b0, 1'b0);
         step();
         drv(1'b0, 32'h0, 1'b1, 1'b0);
         step();
         chk_state($sformatf("wrap%0d", i), 1'b1, 32'(100 + i), 4'd0, 1'b0, 16'd0);
      end
      drv(1'b0, 32'h0, 1'b0, 1'b0);
      step();

      // Clear coinciding with a drop: the drop wins.
      for (int i = 0; i < 10; i++) begin
         capture_word(32'(300 + i), (i < 8) ? 4'(i + 1) : 4'd8, (i >= 8),
                      (i >= 8) ? 16'(i - 7) : 16'd0);
      end
      drv(1'b1, 32'hEE, 1'b0, 1'b1);
      step();
      chk_state("clr_drop", 1'b0, 32'h0, 4'd8, 1'b1, 16'd1);
      drv(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      chk_state("clr_only", 1'b0, 32'h0, 4'd8, 1'b0, 16'd0);

      // Reset with three words stored and a read requested in the same cycle.
      drv(1'b0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) capture_word(32'(400 + i), 4'(i + 1), 1'b0, 16'd0);
      chk_state("pre_rst", 1'b0, 32'h0, 4'd3, 1'b0, 16'd0);
      drv(1'b0, 32'h0, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      chk_state("mid_rst", 1'b0, 32'h0, 4'd0, 1'b0, 16'd0);
      chk("mid_rst.data", host_rd_data, 32'h0);
      reset = 1'b0;
      step();
      chk_state("post_rst", 1'b0, 32'h0, 4'd0, 1'b0, 16'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/elpis_print_buffer.md
Name: elpis_print_buffer

Overview:
Sits directly downstream of the Elpis top-level print path and consumes output_enabled_from_elpis_to_pico / output_data_from_elpis_to_pico. It captures each printed 32-bit word into a small synchronous FIFO, so the host (pico) can drain prints at its own pace through a request/valid read handshake. Words arriving while the FIFO is full are dropped and counted, and a sticky overflow flag is raised.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
ADDR_W, 3, log2(DEPTH).
CAPTURE_ON_EDGE, 1, 1 = capture a word only on a 0->1 transition of print_valid; 0 = capture every cycle print_valid is high.

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
print_valid  in  1  output_enabled_from_elpis_to_pico
print_data  in  32  output_data_from_elpis_to_pico
host_rd_req  in  1  host requests one word; single-cycle pulse or level
host_rd_data  out  32  registered read data
host_rd_valid  out  1  one-cycle pulse; host_rd_data is valid in that cycle
fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH
fifo_empty  out  1  fifo_count == 0
fifo_full  out  1  fifo_count == DEPTH
overflow  out  1  sticky; set when a capture is dropped
drop_count  out  16  number of dropped captures, saturating at 16'hFFFF
clear_overflow  in  1  clears overflow and drop_count

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous and active-high.
- Reset values: host_rd_data=0, host_rd_valid=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, drop_count=0, wr_ptr=rd_ptr=0, prev_valid=0.
- Capture event:
  - CAPTURE_ON_EDGE=1: capture = print_valid & ~prev_valid; prev_valid <= print_valid every cycle.
  - CAPTURE_ON_EDGE=0: capture = print_valid.
  - print_data is sampled in the capture cycle.
- Read event: rd = host_rd_req & ~fifo_empty. A request while the FIFO is empty is ignored; it is not queued.
- Write event: wr = capture & (~fifo_full | rd).
- Full with simultaneous read and write: both operations are accepted and fifo_count is unchanged.
- Empty with capture and request in the same cycle: the word is written and the request is ignored (no bypass). fifo_count becomes 1.
- On wr: mem[wr_ptr] <= print_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- On rd: host_rd_data <= mem[rd_ptr]; host_rd_valid <= 1 in the next cycle; rd_ptr <= rd_ptr+1, wrapping.
- Read latency: 1 cycle from the accepted request to host_rd_valid. When there is no rd, host_rd_valid <= 0 and host_rd_data holds its last value.
- If host_rd_req is held high, one word is popped per cycle until the FIFO is empty, giving back-to-back valid pulses.
- fifo_count: +1 on wr only, -1 on rd only, unchanged on both or neither. fifo_empty and fifo_full are derived combinationally from the registered count.
- Drop: capture & fifo_full & ~rd. overflow <= 1 and drop_count <= drop_count+1, saturating.
- clear_overflow: overflow <= 0 and drop_count <= 0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Reset mid-operation: all pending contents are discarded. A host_rd_valid pulse scheduled for the next cycle is suppressed. Memory contents need not be cleared.

Decomposition:
- Shared definitions file:
  - print word width constant (32)
  - default print FIFO depth constant
  - drop counter width constant (16)
- One sub-module, elpis_sync_fifo:
  - contains pointers, count and storage
  - exposes wr/rd/full/empty/count
- elpis_print_buffer keeps the edge detector, the drop/overflow logic and the read-valid register.

Test Plan:
1. Reset, then pulse print_valid for one cycle with data 32'hDEADBEEF → fifo_count=1. Pulse host_rd_req → next cycle host_rd_valid=1 with host_rd_data=32'hDEADBEEF, fifo_count=0, fifo_empty=1.
2. CAPTURE_ON_EDGE=1: hold print_valid high for 5 cycles with data 32'h1 → exactly one word captured, fifo_count=1.
3. Capture 10 distinct words (0..9), DEPTH=8, no reads → fifo_full=1, overflow=1, drop_count=2. Drain → words 0..7 in order with back-to-back valid pulses.
4. FIFO full, capture word 32'hA5 and request a read in the same cycle → oldest word is returned, fifo_count stays 8, overflow stays 0. The last word drained is 32'hA5.
5. Empty FIFO, capture 32'h55 and request a read in the same cycle → no host_rd_valid next cycle, fifo_count=1.
6. Pointer wrap: 20 write/read pairs with values 100..119 → output order is preserved. Then assert clear_overflow in a cycle where a drop occurs → overflow=1, drop_count=1. Assert reset while 3 words are stored → fifo_count=0 and host_rd_valid=0 on the next cycle.
